lsu_pmem_ctrl: RTL and testbench
================================

LSU_PMEM_CTRL -- requirements
Module: lsu_pmem_ctrl

Interface
REQ-001 Parameters: none; data and address widths are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request from execute stage.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 in_op  in  4  {is_store, sext, size[1:0]}; size 00=byte, 01=half, 10=word.
REQ-007 in_addr  in  32  byte address.
REQ-008 in_wdata  in  32  store data, LSB-aligned.
REQ-009 out_valid  out  1  result available to writeback.
REQ-010 out_ready  in  1  writeback accepts result.
REQ-011 out_rdata  out  32  extended load data; 0 for stores.
REQ-012 out_err  out  1  misaligned-access flag; tied 0 when LSU_MISALIGN_TRAP_EN is undefined.
REQ-013 pmem_valid  out  1  memory request strobe.
REQ-014 pmem_raddr, pmem_waddr  out  32 each  word-aligned address ({in_addr[31:2],2'b00}).
REQ-015 pmem_rdata  in  32  word read data, registered by memory, valid the cycle after pmem_valid.
REQ-016 pmem_wen  out  1  write enable, asserted only with pmem_valid.
REQ-017 pmem_wdata  out  32; pmem_wmask  out  8  lane-shifted data and byte mask; mask[7:4]=0.

Function
REQ-018 FSM states IDLE, REQ, RESP, DONE; a registered state is the only control state.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch op/addr/wdata, go to REQ.
REQ-020 REQ: pmem_valid=1 for exactly one cycle; pmem_wen=is_store; go to RESP.
REQ-021 RESP: capture pmem_rdata, form the result, go to DONE.
REQ-022 DONE: out_valid=1 with out_rdata/out_err held stable until out_ready; on out_valid&&out_ready go to IDLE.
REQ-023 in_ready is 0 in REQ, RESP and DONE; one request is in flight at most; accept-to-out_valid latency is 3 cycles.
REQ-024 Lane offset off=addr[1:0] (byte), {addr[1],1'b0} (half), 2'b00 (word).
REQ-025 Store: pmem_wdata = in_wdata << (8*off); mask = 0001/0011/1111 (byte/half/word) << off.
REQ-026 Load: lane = pmem_rdata >> (8*off), truncated to size; sext=1 sign-extends, sext=0 zero-extends to 32 bits.
REQ-027 pmem_valid, pmem_wen and pmem_wmask are 0 in every state except REQ.
REQ-028 size=11 is treated as word.
REQ-029 If out_ready=1 in DONE and in_valid is already high, the new request is accepted no earlier than the following IDLE cycle; there is no bypass.

Reset
REQ-030 rst takes priority over all inputs; the next state is IDLE.
REQ-031 After reset: in_ready=1, out_valid=0, out_rdata=0, out_err=0, pmem_valid=0, pmem_wen=0, pmem_wmask=0.
REQ-032 Reset asserted in REQ, RESP or DONE discards the in-flight request; no result is ever returned for it.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 skips REQ.
REQ-034 In that case the block goes directly to DONE with out_err=1, out_rdata=0, and pmem_valid stays 0.
REQ-035 When undefined: offsets are forced per REQ-024, an access is never flagged, and out_err is constant 0.

Structure
REQ-036 Shared package lsu_pkg holds the FSM state enum, the size encodings and the in_op field positions.
REQ-037 Combinational sub-module lsu_lane_align performs store shift/mask generation and load extract/extend.

Verification
REQ-038 Load word at 0x80000004, memory 0xDEADBEEF, op=0010 -> out_rdata=0xDEADBEEF three cycles after accept.
REQ-039 Load byte with sext at 0x80000003, memory 0x80FFFFFF, op=0100 -> out_rdata=0xFFFFFF80; with op=0000 -> 0x00000080.
REQ-040 Store half at 0x80000002, in_wdata=0x1234, op=1001 -> pmem_wdata=0x12340000, wmask=8'h0C, wen pulse is 1 cycle.
REQ-041 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_rdata stable, in_ready=0, no pmem_valid pulse.
REQ-042 Assert rst in RESP -> next cycle IDLE, out_valid=0, no result ever returned.
REQ-043 With LSU_MISALIGN_TRAP_EN, load word at 0x80000001 -> out_err=1, pmem_valid never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit physical-memory controller.
//   lsu_state_e    : controller FSM states
//   lsu_size_e     : access size encodings carried in in_op[1:0]
//   Op*            : bit positions of the fields inside in_op
//   lsu_lane_off   : byte-lane offset of an access inside its 32-bit word
//   lsu_misaligned : true when a half/word access is not naturally aligned
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_e;

  // 2'b11 is not a legal encoding and is handled as a word access.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } lsu_size_e;

  // in_op = {is_store, sext, size[1:0]}
  localparam int unsigned OpStoreBit = 3;
  localparam int unsigned OpSextBit  = 2;
  localparam int unsigned OpSizeMsb  = 1;
  localparam int unsigned OpSizeLsb  = 0;

  // Half accesses drop addr[0] and word accesses drop addr[1:0], so a lane
  // can never spill past the top of the word.
  function automatic logic [1:0] lsu_lane_off(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SizeByte: off = addr_lo;
      SizeHalf: off = {addr_lo[1], 1'b0};
      default:  off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the LSU.
//   size_i        : access size (byte/half/word, 2'b11 = word)
//   sext_i        : 1 = sign-extend loads, 0 = zero-extend
//   addr_lo_i     : byte address bits [1:0]
//   store_data_i  : LSB-aligned store data
//   load_word_i   : raw 32-bit word returned by memory
//   store_word_o  : store data shifted into its byte lanes
//   store_mask_o  : byte-enable mask for the shifted store
//   load_data_o   : extracted and extended load result
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] store_word_o,
  output logic [3:0]  store_mask_o,
  output logic [31:0] load_data_o
);

  logic [1:0]  off;
  logic [4:0]  bit_shift;
  logic [3:0]  base_mask;
  logic [31:0] lane;

  assign off       = lsu_lane_off(size_i, addr_lo_i);
  assign bit_shift = {off, 3'b000};

  always_comb begin
    base_mask = 4'b1111;
    case (size_i)
      SizeByte: base_mask = 4'b0001;
      SizeHalf: base_mask = 4'b0011;
      default:  base_mask = 4'b1111;
    endcase
  end

  assign store_word_o = store_data_i << bit_shift;
  assign store_mask_o = base_mask << off;

  assign lane = load_word_i >> bit_shift;

  always_comb begin
    load_data_o = lane;
    case (size_i)
      SizeByte: load_data_o = {{24{sext_i & lane[7]}}, lane[7:0]};
      SizeHalf: load_data_o = {{16{sext_i & lane[15]}}, lane[15:0]};
      default:  load_data_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu_pmem_ctrl.sv
// LSU physical-memory controller: takes one load/store request at a time from
// execute, issues a single-cycle word access to memory and returns the aligned,
// extended load result to writeback.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : request handshake
//   in_op/in_addr/in_wdata       : {is_store, sext, size}, byte address, store data
//   out_valid/out_ready          : result handshake
//   out_rdata/out_err            : load result (0 for stores), misalignment flag
//   pmem_valid/pmem_wen          : memory strobe and write enable (REQ state only)
//   pmem_raddr/pmem_waddr        : word-aligned address
//   pmem_wdata/pmem_wmask        : lane-shifted store data and byte mask
//   pmem_rdata                   : memory read data, valid the cycle after pmem_valid
// Build option: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses with out_err instead of silently forcing the lane offset.
module lsu_pmem_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        pmem_valid,
  output logic [31:0] pmem_raddr,
  output logic [31:0] pmem_waddr,
  input  logic [31:0] pmem_rdata,
  output logic        pmem_wen,
  output logic [31:0] pmem_wdata,
  output logic [7:0]  pmem_wmask
);

  lsu_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  store_mask;
  logic [31:0] store_word;
  logic [31:0] load_data;

  lsu_lane_align u_lane_align (
    .size_i       (op_q[OpSizeMsb:OpSizeLsb]),
    .sext_i       (op_q[OpSextBit]),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (wdata_q),
    .load_word_i  (pmem_rdata),
    .store_word_o (store_word),
    .store_mask_o (store_mask),
    .load_data_o  (load_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;
  logic in_misaligned;

  assign in_misaligned = lsu_misaligned(in_op[OpSizeMsb:OpSizeLsb], in_addr[1:0]);
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d      = err_q;
`endif
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    pmem_valid = 1'b0;
    pmem_wen   = 1'b0;
    pmem_wmask = 8'h00;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          state_d = StReq;
`ifdef LSU_MISALIGN_TRAP_EN
          err_d   = 1'b0;
          // Misaligned accesses never reach memory; report straight away.
          if (in_misaligned) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StDone;
          end
`endif
        end
      end
      StReq: begin
        pmem_valid = 1'b1;
        pmem_wen   = op_q[OpStoreBit];
        pmem_wmask = op_q[OpStoreBit] ? {4'b0000, store_mask} : 8'h00;
        state_d    = StResp;
      end
      StResp: begin
        rdata_d = op_q[OpStoreBit] ? 32'h0 : load_data;
        state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  assign pmem_raddr = {addr_q[31:2], 2'b00};
  assign pmem_waddr = {addr_q[31:2], 2'b00};
  assign pmem_wdata = store_word;
  assign out_rdata  = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_pmem_ctrl.sv
// Directed bench for lsu_pmem_ctrl: a table of single transactions plus
// hand-written sequences for back-pressure, reset mid-flight and trapping.
module tb_lsu_pmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        pmem_valid;
  logic [31:0] pmem_raddr;
  logic [31:0] pmem_waddr;
  logic [31:0] pmem_rdata;
  logic        pmem_wen;
  logic [31:0] pmem_wdata;
  logic [7:0]  pmem_wmask;

  logic [31:0] mem_word;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_pmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_err    (out_err),
    .pmem_valid (pmem_valid),
    .pmem_raddr (pmem_raddr),
    .pmem_waddr (pmem_waddr),
    .pmem_rdata (pmem_rdata),
    .pmem_wen   (pmem_wen),
    .pmem_wdata (pmem_wdata),
    .pmem_wmask (pmem_wmask)
  );

  // Memory model: registered read data the cycle after the strobe.
  always @(posedge clk) begin
    if (pmem_valid) pmem_rdata <= mem_word;
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic [31:0] rdata;   // expected out_rdata
    logic [31:0] pwdata;  // expected pmem_wdata (stores)
    logic [7:0]  mask;    // expected pmem_wmask (stores)
    logic        misal;   // traps when LSU_MISALIGN_TRAP_EN is defined
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    mem_word = v.mem;
    in_op    = v.op;
    in_addr  = v.addr;
    in_wdata = v.wdata;
    in_valid = 1'b1;
    chk({t, " idle in_ready"}, {31'b0, in_ready}, 32'd1);
    step();  // REQ
    in_valid = 1'b0;
    chk({t, " req pmem_valid"}, {31'b0, pmem_valid}, 32'd1);
    chk({t, " req pmem_wen"}, {31'b0, pmem_wen}, {31'b0, v.op[3]});
    chk({t, " req raddr"}, pmem_raddr, {v.addr[31:2], 2'b00});
    chk({t, " req waddr"}, pmem_waddr, {v.addr[31:2], 2'b00});
    chk({t, " req in_ready"}, {31'b0, in_ready}, 32'd0);
    if (v.op[3]) begin
      chk({t, " req wdata"}, pmem_wdata, v.pwdata);
      chk({t, " req wmask"}, {24'b0, pmem_wmask}, {24'b0, v.mask});
    end
    step();  // RESP
    chk({t, " resp pmem_valid"}, {31'b0, pmem_valid}, 32'd0);
    chk({t, " resp pmem_wen"}, {31'b0, pmem_wen}, 32'd0);
    chk({t, " resp wmask"}, {24'b0, pmem_wmask}, 32'd0);
    chk({t, " resp out_valid"}, {31'b0, out_valid}, 32'd0);
    step();  // DONE: three cycles after accept
    chk({t, " done out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({t, " done rdata"}, out_rdata, v.rdata);
    chk({t, " done err"}, {31'b0, out_err}, 32'd0);
    out_ready = 1'b1;
    step();  // IDLE
    out_ready = 1'b0;
    chk({t, " after out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({t, " after in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    //        op     addr          wdata         mem           rdata         pwdata        mask  mis
    vecs[0]  = '{4'b0010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,        8'h00, 1'b0};
    vecs[1]  = '{4'b0100, 32'h8000_0003, 32'h0,        32'h80FF_FFFF, 32'hFFFF_FF80, 32'h0,        8'h00, 1'b0};
    vecs[2]  = '{4'b0000, 32'h8000_0003, 32'h0,        32'h80FF_FFFF, 32'h0000_0080, 32'h0,        8'h00, 1'b0};
    vecs[3]  = '{4'b1001, 32'h8000_0002, 32'h0000_1234, 32'h0,       32'h0,        32'h1234_0000, 8'h0C, 1'b0};
    vecs[4]  = '{4'b0101, 32'h0000_0010, 32'h0,        32'h1234_8765, 32'hFFFF_8765, 32'h0,        8'h00, 1'b0};
    vecs[5]  = '{4'b0001, 32'h0000_0012, 32'h0,        32'h8765_1234, 32'h0000_8765, 32'h0,        8'h00, 1'b0};
    vecs[6]  = '{4'b1000, 32'h0000_0021, 32'h0000_00AB, 32'h0,       32'h0,        32'h0000_AB00, 8'h02, 1'b0};
    vecs[7]  = '{4'b1010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,       32'h0,        32'hCAFE_F00D, 8'h0F, 1'b0};
    vecs[8]  = '{4'b0011, 32'h0000_0044, 32'h0,        32'h0123_4567, 32'h0123_4567, 32'h0,        8'h00, 1'b0};
    vecs[9]  = '{4'b0101, 32'h0000_0013, 32'h0,        32'hF00D_0000, 32'hFFFF_F00D, 32'h0,        8'h00, 1'b1};
    vecs[10] = '{4'b0010, 32'h0000_0022, 32'h0,        32'hAABB_CCDD, 32'hAABB_CCDD, 32'h0,        8'h00, 1'b1};
    vecs[11] = '{4'b1000, 32'h0000_0023, 32'h0000_01FF, 32'h0,       32'h0,        32'hFF00_0000, 8'h08, 1'b0};
    vecs[12] = '{4'b0100, 32'h0000_0022, 32'h0,        32'h117F_3344, 32'h0000_007F, 32'h0,        8'h00, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_addr   = 32'h0;
    in_wdata  = 32'h0;
    out_ready = 1'b0;
    mem_word  = 32'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_rdata", out_rdata, 32'h0);
    chk("rst out_err", {31'b0, out_err}, 32'd0);
    chk("rst pmem_valid", {31'b0, pmem_valid}, 32'd0);
    chk("rst pmem_wen", {31'b0, pmem_wen}, 32'd0);
    chk("rst pmem_wmask", {24'b0, pmem_wmask}, 32'd0);

    for (int i = 0; i < NVec; i++) begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (!vecs[i].misal) run_vec(i);
`else
      run_vec(i);
`endif
    end

    // Back-pressure in DONE with a new request already waiting.
    mem_word = 32'h1357_2468;
    in_op    = 4'b0010;
    in_addr  = 32'h8000_0008;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("hold done out_valid", {31'b0, out_valid}, 32'd1);
    chk("hold done rdata", out_rdata, 32'h1357_2468);
    held     = out_rdata;
    mem_word = 32'h0000_00C3;
    in_op    = 4'b0100;
    in_addr  = 32'h8000_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d rdata", k), out_rdata, held);
      chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("hold%0d pmem_valid", k), {31'b0, pmem_valid}, 32'd0);
    end
    out_ready = 1'b1;
    step();  // back to IDLE, waiting request not yet taken
    out_ready = 1'b0;
    chk("nobypass in_ready", {31'b0, in_ready}, 32'd1);
    chk("nobypass out_valid", {31'b0, out_valid}, 32'd0);
    chk("nobypass pmem_valid", {31'b0, pmem_valid}, 32'd0);
    step();  // REQ for the waiting request
    in_valid = 1'b0;
    chk("next req pmem_valid", {31'b0, pmem_valid}, 32'd1);
    chk("next req raddr", pmem_raddr, 32'h8000_0000);
    step();
    step();
    chk("next done out_valid", {31'b0, out_valid}, 32'd1);
    chk("next done rdata", out_rdata, 32'hFFFF_FFC3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while in RESP discards the request.
    mem_word = 32'h5555_AAAA;
    in_op    = 4'b0010;
    in_addr  = 32'h0000_0100;
    in_valid = 1'b1;
    step();  // REQ
    in_valid = 1'b0;
    step();  // RESP
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstresp in_ready", {31'b0, in_ready}, 32'd1);
    chk("rstresp out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstresp pmem_valid", {31'b0, pmem_valid}, 32'd0);
    chk("rstresp rdata", out_rdata, 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rstresp%0d out_valid", k), {31'b0, out_valid}, 32'd0);
      chk($sformatf("rstresp%0d pmem_valid", k), {31'b0, pmem_valid}, 32'd0);
    end
    out_ready = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching memory.
    in_op    = 4'b0010;
    in_addr  = 32'h8000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("trap pmem_valid", {31'b0, pmem_valid}, 32'd0);
    chk("trap out_valid", {31'b0, out_valid}, 32'd1);
    chk("trap out_err", {31'b0, out_err}, 32'd1);
    chk("trap rdata", out_rdata, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("trap after pmem_valid", {31'b0, pmem_valid}, 32'd0);
    chk("trap after in_ready", {31'b0, in_ready}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
